pattern_led_seq: RTL
====================

Name: pattern_led_seq

Overview:
Parametrised successor to the 4-bit button-driven LED string block. It drives an N_LED-wide LED string in one of four button-selected animation modes: rotate-left, rotate-right, ping-pong and fill/clear. Steps advance at a programmable prescaled rate rather than every clock. It sits between the board push-buttons and the LED pins in the lab top level.

Parameters:
N_LED, 4, number of LEDs driven (legal range 2..32)
TICK_DIV, 4, clock cycles per animation step (legal range 1..2^16)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
but  input  4  level button inputs; but[0]=SHL, but[1]=SHR, but[2]=BNC, but[3]=FILL
led  output  N_LED  LED drive, registered
mode  output  3  current mode code, registered
tick  output  1  one-cycle pulse on every cycle in which led advances

Behaviour:
- Reset, asserted asynchronously while rst=0: led=0, mode=IDLE, tick=0, prescaler count=0, bounce direction=up. All outputs are registered.
- Mode decode is fixed priority, lowest index wins (e.g. but=4'b0110 selects SHR). If but=0, the current mode is kept and keeps running.
- Mode load: at a rising edge where but!=0 and the decoded mode != current mode:
  - mode takes the new code and led takes that mode's start pattern on the same edge (1-cycle latency from the sampled button).
  - The prescaler clears to 0, tick=0 that cycle, and direction is set to up.
- The same button held continuously does nothing extra: no reload, and the animation continues.
- Prescaler:
  - Width is clog2(TICK_DIV), minimum 1.
  - The count increments each cycle while mode!=IDLE. At count==TICK_DIV-1 it wraps to 0 and a step occurs.
  - With TICK_DIV=1, a step occurs every cycle after the load.
  - The first step after a load is TICK_DIV cycles after the load edge.
  - tick is registered high in the same cycle that led shows the stepped value.
- IDLE: led holds 0, no ticks, and the prescaler is held at 0.
- SHL: start pattern 0..01. Each step rotates left and the MSB wraps to the LSB.
- SHR: start pattern 10..0. Each step rotates right and the LSB wraps to the MSB.
- BNC (ping-pong): start pattern 0..01, direction up.
  - Up: shift left; when led[N_LED-1]=1 the step shifts right instead and direction becomes down.
  - Down: mirror behaviour at led[0].
  - The end LEDs are never lit twice in a row. N_LED=4 sequence: 0001,0010,0100,1000,0100,0010,0001,0010,...
- FILL: start pattern 0..01.
  - Each step shifts left inserting 1, i.e. {led[N_LED-2:0],1'b1}.
  - When led is all-ones, the next step gives all-zeros; the step after that gives 0..01.
  - N_LED=4 sequence: 0001,0011,0111,1111,0000,0001,...
- A mode change on the same edge as a prescaler wrap: the load wins, there is no step and tick=0.
- Reset mid-animation returns immediately to IDLE/led=0. After release, nothing happens until a button is seen.
- Only one LED is ever lit in SHL, SHR and BNC.

Decomposition:
- Package led_seq_pkg holds:
  - Mode localparams: IDLE=3'd0, SHL=3'd1, SHR=3'd2, BNC=3'd3, FILL=3'd4.
  - MODE_W=3.
  - A clog2-based width function for the prescaler.
- One sub-module, led_tick_gen, parametrised by TICK_DIV:
  - Inputs: clk, rst, en, clr.
  - Output: step pulse.
  - Holds the prescaler.
- The top level holds mode decode, the pattern registers and the direction flag.

Test Plan:
Common conditions: N_LED=4, TICK_DIV=4, 10 ns clock.
1. Reset: rst=0 for 100 ns, but=0 -> led=0000, mode=0, tick=0. Hold rst=1 with but=0 for 200 ns -> outputs unchanged.
2. SHL: but=0001 for 1 cycle then 0 -> led=0001 on the next edge, then 0010, 0100, 1000, 0001 every 4 cycles. tick pulses once per 4 cycles; mode=1 is retained with but=0.
3. BNC: select but=0100 -> led 0001,0010,0100,1000,0100,0010,0001,0010 across 7 steps (28 cycles); 1000 appears exactly once per bounce.
4. FILL then priority: but=1000 -> 0001,0011,0111,1111,0000,0001. Then but=1010 -> mode=2 (SHR), led=1000 next edge, prescaler restarted with the first step 4 cycles later (0100).
5. Collision and async reset:
   - Change the button on the exact cycle the prescaler wraps -> start pattern loaded, no step, tick=0.
   - Pull rst low between clock edges mid-SHR -> led=0000 immediately, before the next edge.
6. TICK_DIV=1, N_LED=8, SHR -> led advances every cycle: 10000000, 01000000, ..., 00000001, 10000000; tick is high continuously after the load.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared mode codes and prescaler sizing helper for the pattern LED sequencer.
package led_seq_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] IDLE = 3'd0;
    localparam logic [MODE_W-1:0] SHL  = 3'd1;
    localparam logic [MODE_W-1:0] SHR  = 3'd2;
    localparam logic [MODE_W-1:0] BNC  = 3'd3;
    localparam logic [MODE_W-1:0] FILL = 3'd4;

    // A divide-by-1 or -2 still needs one counter bit to stay legal.
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: emits a one-cycle step on every TICK_DIV-th enabled cycle after a clear.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int              CNT_W = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);
    // A clear on the wrap cycle suppresses the step so a mode load always wins.
    assign step   = en && !clr && w_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || !en || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pattern_led_seq.sv
// Button-selected LED animation (rotate left/right, ping-pong, fill/clear) stepped by a prescaler.
module pattern_led_seq
    import led_seq_pkg::*;
#(
    parameter int N_LED    = 4,
    parameter int TICK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        but,
    output logic [N_LED-1:0]  led,
    output logic [MODE_W-1:0] mode,
    output logic              tick
);

    localparam logic [N_LED-1:0] PAT_LSB = N_LED'(1);
    localparam logic [N_LED-1:0] PAT_MSB = {1'b1, {(N_LED-1){1'b0}}};

    logic [N_LED-1:0]  r_led;
    logic [MODE_W-1:0] r_mode;
    logic              r_tick;
    logic              r_dir_up;

    logic [MODE_W-1:0] w_new_mode;
    logic              w_load;
    logic              w_step;
    logic [N_LED-1:0]  w_start;
    logic [N_LED-1:0]  w_next_led;
    logic              w_next_up;

    // Fixed priority: the lowest-numbered pressed button selects the mode.
    always_comb begin
        w_new_mode = r_mode;
        if (but[0])      w_new_mode = SHL;
        else if (but[1]) w_new_mode = SHR;
        else if (but[2]) w_new_mode = BNC;
        else if (but[3]) w_new_mode = FILL;
    end

    assign w_load  = (but != 4'b0000) && (w_new_mode != r_mode);
    assign w_start = (w_new_mode == SHR) ? PAT_MSB : PAT_LSB;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (r_mode != IDLE),
        .clr  (w_load),
        .step (w_step)
    );

    always_comb begin
        w_next_led = r_led;
        w_next_up  = r_dir_up;
        case (r_mode)
            SHL: w_next_led = {r_led[N_LED-2:0], r_led[N_LED-1]};
            SHR: w_next_led = {r_led[0], r_led[N_LED-1:1]};
            BNC: begin
                // Reverse on the end LED itself so neither end is lit twice in a row.
                if (r_dir_up) begin
                    if (r_led[N_LED-1]) begin
                        w_next_led = r_led >> 1;
                        w_next_up  = 1'b0;
                    end else begin
                        w_next_led = r_led << 1;
                    end
                end else begin
                    if (r_led[0]) begin
                        w_next_led = r_led << 1;
                        w_next_up  = 1'b1;
                    end else begin
                        w_next_led = r_led >> 1;
                    end
                end
            end
            FILL: w_next_led = (&r_led) ? '0 : {r_led[N_LED-2:0], 1'b1};
            default: w_next_led = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led    <= '0;
            r_mode   <= IDLE;
            r_tick   <= 1'b0;
            r_dir_up <= 1'b1;
        end else if (w_load) begin
            r_mode   <= w_new_mode;
            r_led    <= w_start;
            r_tick   <= 1'b0;
            r_dir_up <= 1'b1;
        end else begin
            r_tick <= w_step;
            if (w_step) begin
                r_led    <= w_next_led;
                r_dir_up <= w_next_up;
            end
        end
    end

    assign led  = r_led;
    assign mode = r_mode;
    assign tick = r_tick;

endmodule
